// File: rtl/cube_move_sequencer.sv
// Cube state register, move FIFO and one-move-per-clock sequencer.
// Face-turn permutations are applied combinationally to the FIFO head.
module cube_move_sequencer #(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        mv_valid,
  output logic                        mv_ready,
  input  logic [5:0]                  mv_face,
  input  logic [1:0]                  mv_rot,
  input  logic                        cmd_solve,
  input  logic                        cmd_load,
  input  logic [161:0]                load_state,
  input  logic                        pause,
  output logic [161:0]                cube_state,
  output logic                        solved,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic [CNT_W-1:0]            move_count,
  output logic                        illegal_move
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam logic [PtrW:0] LevelFull = (PtrW + 1)'(FIFO_DEPTH);
  localparam logic [PtrW:0] LevelOne  = (PtrW + 1)'(1);
  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StRun  = 1'b1;

  function automatic logic [161:0] solvedPattern();
    logic [161:0] p;
    p = '0;
    for (int i = 0; i < 54; i++) p[3*i +: 3] = 3'(i / 9);
    return p;
  endfunction

  localparam logic [161:0] SolvedState = solvedPattern();

  // Clockwise spin of the 9 stickers of the face starting at facelet base.
  function automatic logic [161:0] spinFace(input logic [161:0] d, input logic [161:0] s,
                                            input int base);
    logic [161:0] n;
    n = d;
    for (int k = 0; k < 9; k++) n[3*(base + (k % 3)*3 + 2 - k/3) +: 3] = s[3*(base + k) +: 3];
    return n;
  endfunction

  // One clockwise quarter turn; face code 0=U 1=R 2=L 3=B 4=F 5=D.
  function automatic logic [161:0] quarterTurn(input logic [161:0] s, input logic [2:0] face);
    logic [161:0] n;
    n = s;
    case (face)
      3'd0: begin
        n = spinFace(n, s, 0);
        for (int c = 0; c < 3; c++) begin
          n[3*(18+c) +: 3] = s[3*(27+c) +: 3];
          n[3*(9+c)  +: 3] = s[3*(18+c) +: 3];
          n[3*(36+c) +: 3] = s[3*(9+c)  +: 3];
          n[3*(27+c) +: 3] = s[3*(36+c) +: 3];
        end
      end
      3'd1: begin
        n = spinFace(n, s, 27);
        for (int r = 0; r < 3; r++) begin
          n[3*(2+3*r)  +: 3] = s[3*(20+3*r) +: 3];
          n[3*(42-3*r) +: 3] = s[3*(2+3*r)  +: 3];
          n[3*(53-3*r) +: 3] = s[3*(36+3*r) +: 3];
          n[3*(20+3*r) +: 3] = s[3*(47+3*r) +: 3];
        end
      end
      3'd2: begin
        n = spinFace(n, s, 9);
        for (int r = 0; r < 3; r++) begin
          n[3*(18+3*r) +: 3] = s[3*(3*r)    +: 3];
          n[3*(45+3*r) +: 3] = s[3*(18+3*r) +: 3];
          n[3*(44-3*r) +: 3] = s[3*(45+3*r) +: 3];
          n[3*(3*r)    +: 3] = s[3*(44-3*r) +: 3];
        end
      end
      3'd3: begin
        n = spinFace(n, s, 36);
        for (int c = 0; c < 3; c++) begin
          n[3*(15-3*c) +: 3] = s[3*c        +: 3];
          n[3*(51+c)   +: 3] = s[3*(9+3*c)  +: 3];
          n[3*(35-3*c) +: 3] = s[3*(51+c)   +: 3];
          n[3*c        +: 3] = s[3*(29+3*c) +: 3];
        end
      end
      3'd4: begin
        n = spinFace(n, s, 18);
        for (int c = 0; c < 3; c++) begin
          n[3*(27+3*c) +: 3] = s[3*(6+c)    +: 3];
          n[3*(47-c)   +: 3] = s[3*(27+3*c) +: 3];
          n[3*(11+3*c) +: 3] = s[3*(45+c)   +: 3];
          n[3*(8-c)    +: 3] = s[3*(11+3*c) +: 3];
        end
      end
      3'd5: begin
        n = spinFace(n, s, 45);
        for (int c = 0; c < 3; c++) begin
          n[3*(33+c) +: 3] = s[3*(24+c) +: 3];
          n[3*(42+c) +: 3] = s[3*(33+c) +: 3];
          n[3*(15+c) +: 3] = s[3*(42+c) +: 3];
          n[3*(24+c) +: 3] = s[3*(15+c) +: 3];
        end
      end
      default: ;
    endcase
    return n;
  endfunction

  logic [7:0]      fifoMem [FIFO_DEPTH];
  logic [PtrW-1:0] wrPtr, rdPtr;
  logic [PtrW:0]   level;
  logic [0:0]      state, stateNext;
  logic [161:0]    cubeQ, q1, q2, q3, turned;
  logic [CNT_W-1:0] countQ;
  logic            illegalQ;
  logic            cmdAny, full, empty, push, pop;
  logic [5:0]      headFace;
  logic [1:0]      headRot;
  logic            headLegal;

  assign cmdAny    = cmd_solve | cmd_load;
  assign full      = (level == LevelFull);
  assign empty     = (state == StIdle);
  assign mv_ready  = rst_n && !full && !cmdAny;
  assign push      = mv_valid && mv_ready;
  assign pop       = !empty && !pause && !cmdAny;
  assign headFace  = fifoMem[rdPtr][7:2];
  assign headRot   = fifoMem[rdPtr][1:0];
  assign headLegal = (headFace < 6'd6);

  always_comb begin
    q1 = quarterTurn(cubeQ, headFace[2:0]);
    q2 = quarterTurn(q1, headFace[2:0]);
    q3 = quarterTurn(q2, headFace[2:0]);
    unique case (headRot)
      2'd1:    turned = q1;
      2'd2:    turned = q2;
      2'd3:    turned = q3;
      default: turned = cubeQ;
    endcase
  end

  always_comb begin
    stateNext = state;
    if (cmdAny) stateNext = StIdle;
    else if (push) stateNext = StRun;
    else if (pop && level == LevelOne) stateNext = StIdle;
  end

  always_ff @(posedge clk) begin
    if (push) fifoMem[wrPtr] <= {mv_face, mv_rot};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cubeQ    <= SolvedState;
      wrPtr    <= '0;
      rdPtr    <= '0;
      level    <= '0;
      countQ   <= '0;
      illegalQ <= 1'b0;
      state    <= StIdle;
    end else begin
      state <= stateNext;
      if (cmdAny) begin
        cubeQ    <= cmd_solve ? SolvedState : load_state;
        wrPtr    <= '0;
        rdPtr    <= '0;
        level    <= '0;
        countQ   <= '0;
        illegalQ <= 1'b0;
      end else begin
        if (push) wrPtr <= wrPtr + 1'b1;
        if (pop) begin
          rdPtr <= rdPtr + 1'b1;
          if (!headLegal) begin
            illegalQ <= 1'b1;
          end else if (headRot != 2'd0) begin
            cubeQ <= turned;
            if (countQ != '1) countQ <= countQ + 1'b1;
          end
        end
        unique case ({push, pop})
          2'b10:   level <= level + 1'b1;
          2'b01:   level <= level - 1'b1;
          default: ;
        endcase
      end
    end
  end

  assign cube_state   = cubeQ;
  assign solved       = (cubeQ == SolvedState);
  assign busy         = (state == StRun);
  assign fifo_level   = level;
  assign move_count   = countQ;
  assign illegal_move = illegalQ;

endmodule

// File: tb/tb_cube_move_sequencer.sv
// Randomized bench for cube_move_sequencer against a geometric cube model.
module tb_cube_move_sequencer;

  localparam int Depth = 8;
  localparam int CntW  = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0, mv_valid = 1'b0, cmd_solve = 1'b0, cmd_load = 1'b0, pause = 1'b0;
  logic [5:0]   mv_face = '0;
  logic [1:0]   mv_rot = '0;
  logic [161:0] load_state = '0;
  logic         mv_ready, solved, busy, illegal_move;
  logic [161:0] cube_state;
  logic [3:0]   fifo_level;
  logic [15:0]  move_count;

  always #5 clk = ~clk;

  cube_move_sequencer #(.FIFO_DEPTH(Depth), .CNT_W(CntW)) dut (
    .clk(clk), .rst_n(rst_n), .mv_valid(mv_valid), .mv_ready(mv_ready), .mv_face(mv_face),
    .mv_rot(mv_rot), .cmd_solve(cmd_solve), .cmd_load(cmd_load), .load_state(load_state),
    .pause(pause), .cube_state(cube_state), .solved(solved), .busy(busy),
    .fifo_level(fifo_level), .move_count(move_count), .illegal_move(illegal_move)
  );

  int nChecks = 0;
  int nErrors = 0;
  bit checkEn = 0;

  task automatic chk(input string name, input logic [161:0] act, input logic [161:0] exp);
    nChecks++;
    if (act !== exp) begin
      nErrors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Sticker geometry: cubie position and outward normal, x->R, y->U, z->F.
  function automatic void geom(input int i, output int px, output int py, output int pz,
                               output int nx, output int ny, output int nz);
    int r, c;
    r = (i % 9) / 3;
    c = i % 3;
    case (i / 9)
      0:       begin px = c-1; py = 1;   pz = r-1; nx = 0;  ny = 1;  nz = 0;  end
      1:       begin px = -1;  py = 1-r; pz = c-1; nx = -1; ny = 0;  nz = 0;  end
      2:       begin px = c-1; py = 1-r; pz = 1;   nx = 0;  ny = 0;  nz = 1;  end
      3:       begin px = 1;   py = 1-r; pz = 1-c; nx = 1;  ny = 0;  nz = 0;  end
      4:       begin px = 1-c; py = 1-r; pz = -1;  nx = 0;  ny = 0;  nz = -1; end
      default: begin px = c-1; py = -1;  pz = 1-r; nx = 0;  ny = -1; nz = 0;  end
    endcase
  endfunction

  // Clockwise as seen from outside = -90 degrees about the outward axis.
  function automatic void rot90(input int ax, input int ay, input int az, input int vx,
                                input int vy, input int vz, output int ox, output int oy,
                                output int oz);
    int d;
    d  = ax*vx + ay*vy + az*vz;
    ox = -(ay*vz - az*vy) + ax*d;
    oy = -(az*vx - ax*vz) + ay*d;
    oz = -(ax*vy - ay*vx) + az*d;
  endfunction

  int perm [6][54];

  function automatic void buildPerm();
    int ax, ay, az, px, py, pz, nx, ny, nz, qx, qy, qz, mx, my, mz;
    int tx, ty, tz, ux, uy, uz;
    for (int f = 0; f < 6; f++) begin
      ax = 0; ay = 0; az = 0;
      case (f)
        0: ay = 1;
        1: ax = 1;
        2: ax = -1;
        3: az = -1;
        4: az = 1;
        default: ay = -1;
      endcase
      for (int i = 0; i < 54; i++) begin
        geom(i, px, py, pz, nx, ny, nz);
        perm[f][i] = i;
        if (ax*px + ay*py + az*pz == 1) begin
          rot90(ax, ay, az, px, py, pz, qx, qy, qz);
          rot90(ax, ay, az, nx, ny, nz, mx, my, mz);
          for (int j = 0; j < 54; j++) begin
            geom(j, tx, ty, tz, ux, uy, uz);
            if (tx == qx && ty == qy && tz == qz && ux == mx && uy == my && uz == mz)
              perm[f][i] = j;
          end
        end
      end
    end
  endfunction

  int mCube [54];
  int mQ [$];
  int mCount;
  bit mIll;

  function automatic void modelSolve();
    for (int i = 0; i < 54; i++) mCube[i] = i / 9;
  endfunction

  function automatic void modelApply(input int f, input int r);
    int tmp [54];
    for (int k = 0; k < r; k++) begin
      for (int i = 0; i < 54; i++) tmp[perm[f][i]] = mCube[i];
      mCube = tmp;
    end
  endfunction

  function automatic logic [161:0] packModel();
    logic [161:0] v;
    for (int i = 0; i < 54; i++) v[3*i +: 3] = 3'(mCube[i]);
    return v;
  endfunction

  function automatic bit modelSolved();
    bit ok;
    ok = 1'b1;
    for (int i = 0; i < 54; i++) if (mCube[i] != i / 9) ok = 1'b0;
    return ok;
  endfunction

  function automatic void modelStep();
    int e;
    bit doPush;
    if (!rst_n) begin
      modelSolve();
      mQ.delete();
      mCount = 0;
      mIll = 1'b0;
    end else if (cmd_solve || cmd_load) begin
      if (cmd_solve) modelSolve();
      else for (int i = 0; i < 54; i++) mCube[i] = int'(load_state[3*i +: 3]);
      mQ.delete();
      mCount = 0;
      mIll = 1'b0;
    end else begin
      doPush = mv_valid && (mQ.size() < Depth);
      if (mQ.size() > 0 && !pause) begin
        e = mQ.pop_front();
        if (e / 4 > 5) mIll = 1'b1;
        else if (e % 4 != 0) begin
          modelApply(e / 4, e % 4);
          if (mCount < (1 << CntW) - 1) mCount++;
        end
      end
      if (doPush) mQ.push_back(int'(mv_face) * 4 + int'(mv_rot));
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    modelStep();
    #1;
  endtask

  task automatic offer(input int f, input int r);
    mv_valid = 1'b1;
    mv_face  = 6'(f);
    mv_rot   = 2'(r);
  endtask

  always @(negedge clk) begin
    if (checkEn) begin
      chk("cube_state", cube_state, packModel());
      chk("solved", solved, modelSolved());
      chk("busy", busy, mQ.size() != 0);
      chk("fifo_level", fifo_level, mQ.size());
      chk("move_count", move_count, mCount);
      chk("illegal_move", illegal_move, mIll);
      chk("mv_ready", mv_ready, rst_n && mQ.size() < Depth && !cmd_solve && !cmd_load);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 1ms");
    $fatal(1);
  end

  initial begin
    logic [161:0] solvedPat, loadPat;
    logic [191:0] rnd;
    int pauseLvl;
    for (int i = 0; i < 54; i++) begin
      solvedPat[3*i +: 3] = 3'(i / 9);
      loadPat[3*i +: 3]   = 3'(i % 6);
    end
    buildPerm();

    tick();
    checkEn = 1'b1;
    tick();
    rst_n = 1'b1;
    #1;
    chk("rst_cube", cube_state, solvedPat);
    chk("rst_solved", solved, 1);
    chk("rst_ready", mv_ready, 1);
    chk("rst_count", move_count, 0);

    // Single U quarter turn from solved.
    offer(0, 1);
    tick();
    mv_valid = 1'b0;
    chk("u_level", fifo_level, 1);
    chk("u_pending_solved", solved, 1);
    tick();
    chk("u_f18", cube_state[56:54], 3);
    chk("u_f27", cube_state[83:81], 4);
    chk("u_f0", cube_state[2:0], 0);
    chk("u_count", move_count, 1);
    chk("u_solved", solved, 0);

    // Inverse pairs back to back.
    cmd_solve = 1'b1;
    tick();
    cmd_solve = 1'b0;
    offer(1, 2); tick();
    offer(1, 2); tick();
    offer(4, 1); tick();
    chk("r2r2_solved", solved, 1);
    offer(4, 3); tick();
    mv_valid = 1'b0;
    tick();
    chk("inv_solved", solved, 1);
    chk("inv_count", move_count, 4);
    chk("inv_busy", busy, 0);

    // Fill under pause, then drain.
    pause = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      offer($urandom_range(0, 5), $urandom_range(0, 3));
      tick();
      if (k == 8) begin
        chk("full_level", fifo_level, 8);
        chk("full_ready", mv_ready, 0);
      end
    end
    chk("full_level9", fifo_level, 8);
    pause = 1'b0;
    mv_valid = 1'b0;
    tick();
    chk("drain_level", fifo_level, 7);
    chk("drain_ready", mv_ready, 1);
    for (int k = 6; k >= 0; k--) begin
      tick();
      chk("drain_step", fifo_level, k);
    end

    // Illegal and zero-turn entries.
    cmd_solve = 1'b1;
    tick();
    cmd_solve = 1'b0;
    offer(7, 1); tick();
    offer(0, 0); tick();
    mv_valid = 1'b0;
    tick();
    chk("ill_solved", solved, 1);
    chk("ill_count", move_count, 0);
    chk("ill_flag", illegal_move, 1);
    cmd_solve = 1'b1;
    tick();
    cmd_solve = 1'b0;
    chk("ill_clear", illegal_move, 0);

    // Load interrupting a queued burst; offered push must be dropped.
    pause = 1'b1;
    for (int k = 0; k < 5; k++) begin
      offer($urandom_range(0, 5), $urandom_range(1, 3));
      tick();
    end
    chk("burst_level", fifo_level, 5);
    cmd_load   = 1'b1;
    load_state = loadPat;
    offer(1, 1);
    #1;
    chk("cmd_ready", mv_ready, 0);
    tick();
    cmd_load = 1'b0;
    mv_valid = 1'b0;
    pause    = 1'b0;
    chk("load_cube", cube_state, loadPat);
    chk("load_level", fifo_level, 0);
    chk("load_count", move_count, 0);
    chk("load_solved", solved, 0);
    cmd_solve = 1'b1;
    cmd_load  = 1'b1;
    tick();
    cmd_solve = 1'b0;
    cmd_load  = 1'b0;
    chk("both_cube", cube_state, solvedPat);

    // Random traffic against the model.
    for (int it = 0; it < 3000; it++) begin
      pauseLvl  = (it / 300) % 10;
      rst_n     = ($urandom_range(0, 299) != 0);
      cmd_solve = ($urandom_range(0, 79) == 0);
      cmd_load  = ($urandom_range(0, 59) == 0);
      pause     = ($urandom_range(0, 9) < pauseLvl);
      mv_valid  = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 9) == 0) mv_face = 6'($urandom_range(6, 63));
      else mv_face = 6'($urandom_range(0, 5));
      mv_rot = 2'($urandom_range(0, 3));
      rnd = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
      load_state = rnd[161:0];
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule
